// File: rtl/mux_2to1_32bit.sv
// Two-input word selector with a combinational result, a registered copy of it,
// and clocked select-activity status (change pulse and saturating select-B count).
module mux_2to1_32bit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             se_i,
    output logic [WIDTH-1:0] c_o,
    output logic [WIDTH-1:0] c_r_o,
    output logic             se_r_o,
    output logic             sel_chg_o,
    output logic [CNT_W-1:0] sel_b_cnt_o
);

    logic [WIDTH-1:0] c_r_q, c_r_d;
    logic             se_r_q, se_r_d;
    logic             sel_chg_q, sel_chg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Pure select path: must not depend on clock, reset or any register.
    assign c_o = se_i ? b_i : a_i;

    always_comb begin
        c_r_d     = c_o;
        se_r_d    = se_i;
        sel_chg_d = (se_i != se_r_q);
        cnt_d     = cnt_q;
        // Saturate at all-ones rather than wrapping back to zero.
        if (se_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            c_r_q     <= '0;
            se_r_q    <= 1'b0;
            sel_chg_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            c_r_q     <= c_r_d;
            se_r_q    <= se_r_d;
            sel_chg_q <= sel_chg_d;
            cnt_q     <= cnt_d;
        end
    end

    assign c_r_o       = c_r_q;
    assign se_r_o      = se_r_q;
    assign sel_chg_o   = sel_chg_q;
    assign sel_b_cnt_o = cnt_q;

endmodule

// File: tb/tb_mux_2to1_32bit.sv
// Scoreboard bench for mux_2to1_32bit: stimulus pushes expected values,
// a monitor process pops and compares them when a check is requested.
module tb_mux_2to1_32bit;

   localparam int WIDTH = 32;

   typedef enum int {
      K_C, K_CR, K_SER, K_CHG, K_CNT, K_CNT4
   } kindT;

   typedef struct {
      string       name;
      kindT        kind;
      logic [31:0] exp;
   } expT;

   logic             clk = 1'b0;
   logic             clkEn = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             se = 1'b0;

   logic [WIDTH-1:0] c, cR, c4, cR4;
   logic             seR, chg, seR4, chg4;
   logic [15:0]      cnt;
   logic [3:0]       cnt4;

   expT  scoreQ[$];
   event checkEv;
   int   checks = 0;
   int   errors = 0;

   mux_2to1_32bit #(.WIDTH(32), .CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .se_i(se),
      .c_o(c), .c_r_o(cR), .se_r_o(seR), .sel_chg_o(chg), .sel_b_cnt_o(cnt)
   );

   mux_2to1_32bit #(.WIDTH(32), .CNT_W(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .se_i(se),
      .c_o(c4), .c_r_o(cR4), .se_r_o(seR4), .sel_chg_o(chg4), .sel_b_cnt_o(cnt4)
   );

   // Free-running clock, gated so the combinational section runs with no clock.
   always #5 if (clkEn) clk = ~clk;

   function automatic logic [31:0] getActual(kindT k);
      case (k)
         K_C:     return c;
         K_CR:    return cR;
         K_SER:   return {31'b0, seR};
         K_CHG:   return {31'b0, chg};
         K_CNT:   return {16'b0, cnt};
         default: return {28'b0, cnt4};
      endcase
   endfunction

   // Monitor: drains every pending expectation whenever a check is requested.
   initial begin
      forever begin
         @(checkEv);
         while (scoreQ.size() > 0) begin
            expT e;
            logic [31:0] act;
            e   = scoreQ.pop_front();
            act = getActual(e.kind);
            checks++;
            if (act !== e.exp) begin
               errors++;
               $display("[TB] FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
            end
         end
      end
   end

   task automatic pushExp(input string name, input kindT k, input logic [31:0] v);
      expT e;
      e.name = name;
      e.kind = k;
      e.exp  = v;
      scoreQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic sv);
      a  = av;
      b  = bv;
      se = sv;
      #1;
   endtask

   task automatic checkOutput();
      ->checkEv;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushRegsZero(input string tag);
      pushExp({tag, "_cr"},   K_CR,   32'd0);
      pushExp({tag, "_ser"},  K_SER,  32'd0);
      pushExp({tag, "_chg"},  K_CHG,  32'd0);
      pushExp({tag, "_cnt"},  K_CNT,  32'd0);
      pushExp({tag, "_cnt4"}, K_CNT4, 32'd0);
   endtask

   // Main stimulus sequence following the test plan section by section.
   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      logic        selSeq[5];
      logic [31:0] chgSeq[5];
      logic [31:0] cntSeq[5];
      selSeq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      chgSeq = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd1};
      cntSeq = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd2};

      $display("[TB] combinational checks, clock stopped");
      for (int i = 0; i < 100; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         applyStimulus(ra, rb, rs);
         pushExp("rand_c", K_C, rs ? rb : ra);
         checkOutput();
      end
      applyStimulus(32'hDEADBEEF, 32'h12345678, 1'b0);
      pushExp("dir_se0", K_C, 32'hDEADBEEF);
      checkOutput();
      checks++;
      if (c !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL dir_se0_direct: got %h expected %h at %0t", c, 32'hDEADBEEF, $time);
      end
      applyStimulus(32'hDEADBEEF, 32'h12345678, 1'b1);
      pushExp("dir_se1", K_C, 32'h12345678);
      checkOutput();
      checks++;
      if (c !== 32'h12345678) begin
         errors++;
         $display("[TB] FAIL dir_se1_direct: got %h expected %h at %0t", c, 32'h12345678, $time);
      end
      applyStimulus(32'h0, 32'hFFFFFFFF, 1'b0);
      pushExp("zeros_a", K_C, 32'h0);
      checkOutput();
      applyStimulus(32'h0, 32'hFFFFFFFF, 1'b1);
      pushExp("ones_b", K_C, 32'hFFFFFFFF);
      checkOutput();
      applyStimulus(32'hFFFFFFFF, 32'h0, 1'b0);
      pushExp("ones_a", K_C, 32'hFFFFFFFF);
      checkOutput();
      applyStimulus(32'hFFFFFFFF, 32'h0, 1'b1);
      pushExp("zeros_b", K_C, 32'h0);
      checkOutput();

      $display("[TB] registered path");
      clkEn = 1'b1;
      rst = 1'b1;
      tick();
      pushRegsZero("reset");
      checkOutput();
      rst = 1'b0;
      applyStimulus(32'd5, 32'd9, 1'b1);
      pushExp("pre_edge_cr", K_CR, 32'd0);
      checkOutput();
      checks++;
      if (cR !== 32'd0) begin
         errors++;
         $display("[TB] FAIL pre_edge_cr_direct: got %h expected %h at %0t", cR, 32'd0, $time);
      end
      tick();
      pushExp("reg_cr",   K_CR,   32'd9);
      pushExp("reg_ser",  K_SER,  32'd1);
      pushExp("reg_chg",  K_CHG,  32'd1);
      pushExp("reg_cnt",  K_CNT,  32'd1);
      pushExp("reg_cnt4", K_CNT4, 32'd1);
      checkOutput();
      checks++;
      if (cR !== 32'd9) begin
         errors++;
         $display("[TB] FAIL reg_cr_direct: got %h expected %h at %0t", cR, 32'd9, $time);
      end
      checks++;
      if (seR !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reg_ser_direct: got %b expected %b at %0t", seR, 1'b1, $time);
      end

      $display("[TB] change pulse");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(32'hA5A5A5A5, 32'h5A5A5A5A, selSeq[i]);
         tick();
         pushExp($sformatf("chg_%0d", i), K_CHG, chgSeq[i]);
         pushExp($sformatf("chgcnt_%0d", i), K_CNT, cntSeq[i]);
         pushExp($sformatf("chgcr_%0d", i), K_CR, selSeq[i] ? 32'h5A5A5A5A : 32'hA5A5A5A5);
         checkOutput();
      end

      $display("[TB] counter saturation");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(32'd1, 32'd2, 1'b1);
      for (int k = 1; k <= 20; k++) begin
         tick();
         pushExp($sformatf("sat4_%0d", k), K_CNT4, (k > 15) ? 32'd15 : 32'(k));
         pushExp($sformatf("cnt16_%0d", k), K_CNT, 32'(k));
         checkOutput();
      end
      checks++;
      if (cnt4 !== 4'd15) begin
         errors++;
         $display("[TB] FAIL sat4_direct: got %0d expected %0d at %0t", cnt4, 15, $time);
      end
      rst = 1'b1;
      tick();
      pushExp("rst_se1_cnt4", K_CNT4, 32'd0);
      pushExp("rst_se1_cnt",  K_CNT,  32'd0);
      checkOutput();
      checks++;
      if (cnt4 !== 4'd0) begin
         errors++;
         $display("[TB] FAIL rst_se1_cnt4_direct: got %0d expected %0d at %0t", cnt4, 0, $time);
      end

      $display("[TB] reset independence");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(32'h11110000 + 32'(i), 32'h2222FFFF - 32'(i), 1'(i % 2));
         pushExp($sformatf("rstc_%0d", i), K_C, (i % 2) ? 32'h2222FFFF - 32'(i) : 32'h11110000 + 32'(i));
         checkOutput();
         tick();
         pushRegsZero($sformatf("rsthold_%0d", i));
         checkOutput();
      end
      rst = 1'b0;

      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard bound so the bench always terminates.
   initial begin
      #100000;
      errors++;
      $display("[TB] FAIL timeout: got running expected finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] timeout");
   end

endmodule
